// File: rtl/switch_debounce.sv
// Slide-switch conditioner: two-flop synchroniser plus per-channel stability
// filter, with registered per-bit and aggregate change strobes.
module switch_debounce #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] swt_raw,
   output logic [WIDTH-1:0] swt_db,
   output logic [WIDTH-1:0] swt_chg,
   output logic             upd
);

   // The counter must be able to reach STABLE_CYCLES-1 without wrapping.
   generate
      if (STABLE_CYCLES < 2 || (STABLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cfg
         $error("switch_debounce: STABLE_CYCLES=%0d does not fit CNT_W=%0d",
                STABLE_CYCLES, CNT_W);
      end
   endgenerate

   typedef enum logic {
      MATCH = 1'b0,
      COUNT = 1'b1
   } ch_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] chg_q;
   logic [WIDTH-1:0] chg_d;
   logic             upd_q;
   logic             upd_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Per-channel FSM state, decoded from the sync2/debounced comparison.
   ch_state_t        ch_state [WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         chg_q   <= '0;
         upd_q   <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= swt_raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         chg_q   <= chg_d;
         upd_q   <= upd_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      db_d  = db_q;
      chg_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i]    = '0;
         ch_state[i] = (sync2_q[i] != db_q[i]) ? COUNT : MATCH;
         case (ch_state[i])
            COUNT: begin
               // Mismatch has held for STABLE_CYCLES edges: accept it.
               if (cnt_q[i] == CNT_LAST) begin
                  db_d[i]  = sync2_q[i];
                  chg_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: cnt_d[i] = '0;
         endcase
      end
      upd_d = |chg_d;
   end

   assign swt_db  = db_q;
   assign swt_chg = chg_q;
   assign upd     = upd_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=8, CNT_W=4; every
// strobe is also logged and matched against an expected queue at the end.
module tb_switch_debounce;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] swt_raw;
   logic [W-1:0] swt_db;
   logic [W-1:0] swt_chg;
   logic         upd;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   switch_debounce #(
      .WIDTH        (W),
      .STABLE_CYCLES(8),
      .CNT_W        (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .swt_raw(swt_raw),
      .swt_db (swt_db),
      .swt_chg(swt_chg),
      .upd    (upd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] db,
                            input logic [W-1:0] chg, input logic u);
      check({tag, "_db"}, 32'(swt_db), 32'(db));
      check({tag, "_chg"}, 32'(swt_chg), 32'(chg));
      check({tag, "_upd"}, 32'(upd), 32'(u));
   endtask

   // monitor: log every strobe, check upd aggregates swt_chg
   always @(negedge clk) begin
      if (rst_n) begin
         if (swt_chg !== '0) got_q.push_back(swt_chg);
         total++;
         assert (upd === (swt_chg != '0)) else begin
            bad++;
            $error("FAIL upd_or observed=%0h expected=%0h", upd, (swt_chg != '0));
         end
      end
   end

   initial begin
      // reset then hold 4'hF
      rst_n   = 1'b0;
      swt_raw = 4'hF;
      steps(2);
      check_out("reset", 4'h0, 4'h0, 1'b0);
      rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         check("hold_pre_db", 32'(swt_db), 32'h0);
      end
      step();
      check_out("hold_accept", 4'hF, 4'hF, 1'b1);
      exp_q.push_back(4'hF);
      step();
      check_out("hold_after", 4'hF, 4'h0, 1'b0);

      // back to 0, then clean step to 4'h5
      swt_raw = 4'h0;
      steps(10);
      check_out("to_zero", 4'h0, 4'hF, 1'b1);
      exp_q.push_back(4'hF);
      swt_raw = 4'h5;
      steps(9);
      check("step_pre_db", 32'(swt_db), 32'h0);
      step();
      check_out("step_accept", 4'h5, 4'h5, 1'b1);
      exp_q.push_back(4'h5);
      step();
      check_out("step_after", 4'h5, 4'h0, 1'b0);

      // return to 0 before bounce test
      swt_raw = 4'h0;
      steps(10);
      check_out("clr5", 4'h0, 4'h5, 1'b1);
      exp_q.push_back(4'h5);
      step();

      // bounce on bit0: 0,1,0 for 3 clks each, then stays 1
      swt_raw = 4'h0; steps(3);
      swt_raw = 4'h1; steps(3);
      swt_raw = 4'h0; steps(3);
      check("bounce_mid_db", 32'(swt_db), 32'h0);
      swt_raw = 4'h1;
      steps(9);
      check("bounce_pre_db", 32'(swt_db), 32'h0);
      step();
      check_out("bounce_accept", 4'h1, 4'h1, 1'b1);
      exp_q.push_back(4'h1);

      // short glitch on bit3
      swt_raw = 4'h9;
      steps(5);
      swt_raw = 4'h1;
      steps(12);
      check_out("glitch", 4'h1, 4'h0, 1'b0);

      // staggered bit1 then bit2 three clocks later
      swt_raw = 4'h3;
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k == 3) swt_raw = 4'h7;
         if (k == 9)  check("stag9_db", 32'(swt_db), 32'h1);
         if (k == 10) check_out("stag10", 4'h3, 4'h2, 1'b1);
         if (k == 11) check_out("stag11", 4'h3, 4'h0, 1'b0);
         if (k == 12) check("stag12_db", 32'(swt_db), 32'h3);
         if (k == 13) check_out("stag13", 4'h7, 4'h4, 1'b1);
      end
      exp_q.push_back(4'h2);
      exp_q.push_back(4'h4);

      // clear, then async reset mid-count on bit1
      swt_raw = 4'h0;
      steps(10);
      check_out("clr7", 4'h0, 4'h7, 1'b1);
      exp_q.push_back(4'h7);
      step();
      swt_raw = 4'h2;
      steps(7);
      check("midcnt_db", 32'(swt_db), 32'h0);
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 4'h0, 4'h0, 1'b0);
      #2;
      rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         check("rerun_pre_db", 32'(swt_db), 32'h0);
      end
      step();
      check_out("rerun_accept", 4'h2, 4'h2, 1'b1);
      exp_q.push_back(4'h2);
      step();
      check_out("rerun_after", 4'h2, 4'h0, 1'b0);
      steps(2);

      // scoreboard: every logged strobe must match the expected sequence
      check("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         check("strobe_value", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the Nexys4 DDR slide switches. Feeds the 2-bit + 2-bit adder operand inputs.
- Synchronises each raw switch line into the clk domain and filters contact bounce. The downstream adder therefore sees only clean, stable operand bits.
- Also emits per-bit and aggregate one-cycle change strobes, so later stages (display/register logic) can react to operand updates.

Parameters:
- WIDTH, 4, number of switch channels (adder uses swt[3:0] = {b1,b0,a1,a0}).
- STABLE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from the debounced value before it is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W.
- CNT_W, 20, width of each per-channel stability counter.

Ports:
- clk  input  1  board clock (100 MHz); all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- swt_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- swt_db  output  WIDTH  debounced switch levels; drives adder swt inputs.
- swt_chg  output  WIDTH  one-cycle pulse per bit when swt_db[i] changes.
- upd  output  1  one-cycle pulse when any swt_chg bit is set (OR of swt_chg).

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: sync stages, counters, swt_db, swt_chg, upd all 0. Asynchronous on rst_n=0; release takes effect at the next clk edge.
- Synchroniser: two-flop chain per bit, sync1 <= swt_raw, then sync2 <= sync1. No logic between the flops. Only sync2 is used downstream.
- Per-channel FSM, two states:
  - MATCH: sync2[i] == swt_db[i]; cnt[i] held at 0.
  - COUNT: sync2[i] != swt_db[i]; cnt[i] increments each clk.
  - COUNT -> MATCH via bounce: sync2[i] returns equal to swt_db[i] before acceptance. cnt[i] <= 0; swt_db unchanged; no strobe.
  - COUNT -> accept: mismatch is seen on the cycle where cnt[i] == STABLE_CYCLES-1, i.e. the mismatch has persisted for STABLE_CYCLES consecutive edges. Then swt_db[i] <= sync2[i], cnt[i] <= 0, swt_chg[i] <= 1 for exactly one cycle.
- Latency: swt_raw[i] changes and then holds steady. swt_db[i] updates exactly 2 + STABLE_CYCLES rising edges after the first edge that samples the new level. swt_chg[i] and upd assert in the same cycle swt_db[i] changes.
- Registering: swt_chg and upd are registered and deassert the following cycle unless another channel accepts then.
- Channel independence: channels are fully independent. Simultaneous acceptance on several bits sets several swt_chg bits in the same cycle, with a single upd pulse.
- Counter width: cnt never exceeds STABLE_CYCLES-1; no wrap-around is possible. CNT_W must hold STABLE_CYCLES-1; an elaboration-time check flags violation.
- Glitch shorter than STABLE_CYCLES at sync2: fully rejected, no output activity.
- Reset mid-count: counters and swt_db clear immediately. After release, a switch still held high re-qualifies from zero and produces a swt_chg pulse after 2 + STABLE_CYCLES edges.
- No combinational path from swt_raw to any output.

Test Plan (sim with STABLE_CYCLES=8, CNT_W=4):
- Reset then hold: assert rst_n=0 with swt_raw=4'hF, release, hold 4'hF -> swt_db=0 until edge 10 after release, then swt_db=4'hF, swt_chg=4'hF and upd=1 for one cycle only.
- Clean step: swt_raw 4'h0 -> 4'h5, held steady -> swt_db=4'h5 exactly 10 edges later; swt_chg=4'h5 for one cycle; adder LEDs show 3'b010 (1+1).
- Bounce rejection: bit0 toggles 0,1,0,1 every 3 clks, then stays 1 -> no swt_chg until 10 edges after the final rising level; a single pulse follows, and there are no pulses during bouncing.
- Short glitch: bit3 high for 5 clks then low -> swt_db[3] stays 0; swt_chg and upd never assert.
- Staggered channels: bit1 rises at t, bit2 rises at t+3 -> swt_chg=4'h2 at t+10, swt_chg=4'h4 at t+13, two separate upd pulses.
- Async reset mid-count: swt_raw=4'h2, pull rst_n low at count 5 for a partial cycle -> outputs 0 immediately; after release, swt_db[1]=1 only after a full 10 edges.
